// File: rtl/adc_scan_uart.sv
// rtl/adc_scan_uart.sv - masked MCP3008 channel scanner streaming two-byte 8N1 UART records
// Optional macro SCAN_HEADER_EN: prefix every scan with 0xA5 and the latched channel mask.
module adc_scan_uart #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200,
  parameter int SCK_DIV  = 8,
  parameter int NUM_CH   = 8,
  parameter int ADC_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                SCK,
  output logic                SS1,
  output logic                MOSI,
  input  logic                MISO,
  output logic                TxD,
  output logic                busy,
  output logic                sample_valid,
  output logic [2:0]          sample_ch,
  output logic [ADC_BITS-1:0] sample_data
);

  localparam int BAUD_DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF      = SCK_DIV / 2;
  localparam int NUM_SLOTS = 7 + ADC_BITS;
  localparam int GAP_CYC   = 2 * SCK_DIV;
  localparam int CW        = $clog2(GAP_CYC + 1);
  localparam int SW        = $clog2(NUM_SLOTS + 1);
  localparam int BW        = $clog2(BAUD_DIV + 1);

  if (BAUD_DIV < 16) begin : g_baud_chk
    $error("BAUD_DIV must be >= 16");
  end
  if ((SCK_DIV < 4) || (SCK_DIV % 2 != 0)) begin : g_sck_chk
    $error("SCK_DIV must be even and >= 4");
  end
  if ((NUM_CH < 1) || (NUM_CH > 8) || (ADC_BITS < 8) || (ADC_BITS > 12)) begin : g_size_chk
    $error("NUM_CH must be 1..8 and ADC_BITS 8..12");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef SCAN_HEADER_EN
  localparam logic [2:0] ST_HDR   = 3'd1;
`endif
  localparam logic [2:0] ST_CONV  = 3'd2;
  localparam logic [2:0] ST_TX_LO = 3'd3;
  localparam logic [2:0] ST_TX_HI = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       slot;      // 0 = CS lead-in, n = SPI slot n-1
  logic [NUM_CH-1:0]   mask_q;
  logic [2:0]          cur_ch;
  logic [ADC_BITS-1:0] sr;
  logic                mosi_next;
  logic                nxt_found;
  logic                first_found;
  logic [2:0]          nxt_ch;
  logic [2:0]          first_ch;
  logic [3:0]          hi_nib;
  logic                conv_end;
  logic                gap_end;

  logic                tx_load;
  logic [7:0]          tx_byte;
  logic                tx_done;
  logic                tx_active;
  logic [BW-1:0]       baud_cnt;
  logic [3:0]          bit_idx;
  logic [8:0]          tx_sr;

`ifdef SCAN_HEADER_EN
  logic                hdr_second;
  logic                rescan;
  logic [7:0]          mask_byte;

  // Latched mask widened to a full header byte
  always_comb begin
    mask_byte = '0;
    mask_byte[NUM_CH-1:0] = mask_q;
  end
`endif

  assign conv_end = (state == ST_CONV) && (cnt == CW'(SCK_DIV - 1)) && (slot == SW'(NUM_SLOTS));
  assign gap_end  = (state == ST_GAP) && (cnt == CW'(GAP_CYC - 1));
  assign tx_done  = tx_active && (baud_cnt == BW'(BAUD_DIV - 1)) && (bit_idx == 4'd9);

  // Lowest enabled channel of the live mask and next enabled channel above the current one
  always_comb begin
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    first_found = 1'b0;
    first_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_ch))) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = 3'(i);
      end
    end
  end

  // Command bit presented in the slot that follows the current one
  always_comb begin
    mosi_next = 1'b0;
    case (int'(slot))
      0, 1:    mosi_next = 1'b1;
      2:       mosi_next = cur_ch[2];
      3:       mosi_next = cur_ch[1];
      4:       mosi_next = cur_ch[0];
      default: mosi_next = 1'b0;
    endcase
  end

  // Upper nibble of the sample, zero where ADC_BITS leaves no bits
  always_comb begin
    hi_nib = '0;
    for (int i = 8; i < ADC_BITS; i++) begin
      hi_nib[i-8] = sample_data[i];
    end
  end

  // Decide when the UART engine takes its next byte and what that byte is
  always_comb begin
    tx_load = 1'b0;
    tx_byte = '0;
    if (conv_end) begin
      tx_load = 1'b1;
      tx_byte = sr[7:0];
    end else if ((state == ST_TX_LO) && tx_done) begin
      tx_load = 1'b1;
      tx_byte = {1'b1, sample_ch, hi_nib};
    end
`ifdef SCAN_HEADER_EN
    else if ((state == ST_IDLE) && start && first_found) begin
      tx_load = 1'b1;
      tx_byte = 8'hA5;
    end else if (gap_end && rescan) begin
      tx_load = 1'b1;
      tx_byte = 8'hA5;
    end else if ((state == ST_HDR) && tx_done && !hdr_second) begin
      tx_load = 1'b1;
      tx_byte = mask_byte;
    end
`endif
  end

  // 8N1 serialiser; a load on the stop bit's last cycle chains bytes back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TxD       <= 1'b1;
      tx_sr     <= '1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      tx_active <= 1'b0;
    end else if (tx_load) begin
      TxD       <= 1'b0;
      tx_sr     <= {1'b1, tx_byte};
      baud_cnt  <= '0;
      bit_idx   <= '0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (baud_cnt == BW'(BAUD_DIV - 1)) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          TxD     <= tx_sr[0];
          tx_sr   <= {1'b1, tx_sr[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // Scan sequencer: channel walk, SPI conversion timing and sample capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      slot         <= '0;
      mask_q       <= '0;
      cur_ch       <= '0;
      sr           <= '0;
      SCK          <= 1'b0;
      SS1          <= 1'b1;
      MOSI         <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
`ifdef SCAN_HEADER_EN
      hdr_second   <= 1'b0;
      rescan       <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && first_found) begin
            mask_q <= ch_mask;
            cur_ch <= first_ch;
            busy   <= 1'b1;
`ifdef SCAN_HEADER_EN
            hdr_second <= 1'b0;
            state      <= ST_HDR;
`else
            SS1   <= 1'b0;
            MOSI  <= 1'b1;
            cnt   <= '0;
            slot  <= '0;
            state <= ST_CONV;
`endif
          end
        end
`ifdef SCAN_HEADER_EN
        ST_HDR: begin
          if (tx_done) begin
            if (!hdr_second) begin
              hdr_second <= 1'b1;
            end else begin
              SS1   <= 1'b0;
              MOSI  <= 1'b1;
              cnt   <= '0;
              slot  <= '0;
              state <= ST_CONV;
            end
          end
        end
`endif
        ST_CONV: begin
          cnt <= cnt + 1'b1;
          if ((slot != '0) && (cnt == CW'(HALF - 1))) begin
            SCK <= 1'b1;
            sr  <= {sr[ADC_BITS-2:0], MISO};
          end
          if (cnt == CW'(SCK_DIV - 1)) begin
            cnt <= '0;
            SCK <= 1'b0;
            if (conv_end) begin
              SS1          <= 1'b1;
              MOSI         <= 1'b0;
              sample_data  <= sr;
              sample_ch    <= cur_ch;
              sample_valid <= 1'b1;
              state        <= ST_TX_LO;
            end else begin
              slot <= slot + 1'b1;
              MOSI <= mosi_next;
            end
          end
        end
        ST_TX_LO: begin
          if (tx_done) state <= ST_TX_HI;
        end
        ST_TX_HI: begin
          if (tx_done) begin
            cnt <= '0;
            if (nxt_found) begin
              cur_ch <= nxt_ch;
              state  <= ST_GAP;
            end else if (continuous && first_found) begin
              mask_q <= ch_mask;
              cur_ch <= first_ch;
              state  <= ST_GAP;
`ifdef SCAN_HEADER_EN
              rescan <= 1'b1;
`endif
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          cnt <= cnt + 1'b1;
          if (gap_end) begin
            cnt <= '0;
`ifdef SCAN_HEADER_EN
            if (rescan) begin
              rescan     <= 1'b0;
              hdr_second <= 1'b0;
              state      <= ST_HDR;
            end else begin
              SS1   <= 1'b0;
              MOSI  <= 1'b1;
              slot  <= '0;
              state <= ST_CONV;
            end
`else
            SS1   <= 1'b0;
            MOSI  <= 1'b1;
            slot  <= '0;
            state <= ST_CONV;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_uart.sv
// tb/tb_adc_scan_uart.sv - bench for adc_scan_uart with MCP3008 model and UART receiver
`timescale 1ns/1ps
module tb_adc_scan_uart;

  localparam int BD     = (25000000 + 115200 / 2) / 115200;
  localparam int SCKDIV = 8;
`ifdef SCAN_HEADER_EN
  localparam int HN = 2;
`else
  localparam int HN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, continuous, MISO;
  logic [7:0] ch_mask;
  logic       SCK, SS1, MOSI, TxD, busy, sample_valid;
  logic [2:0] sample_ch;
  logic [9:0] sample_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_bytes[$];
  logic [12:0] exp_s[$];
  logic [7:0]  rx_log[$];

  adc_scan_uart #(.CLK_FREQ(25000000), .BAUD(115200), .SCK_DIV(SCKDIV), .NUM_CH(8), .ADC_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .SCK(SCK), .SS1(SS1), .MOSI(MOSI), .MISO(MISO), .TxD(TxD), .busy(busy),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected stream for one scan of mask m
  task automatic scan_expect(input logic [7:0] m);
    logic [9:0] d;
`ifdef SCAN_HEADER_EN
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(m);
`endif
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        d = 10'h2A7 + 10'(c);
        exp_s.push_back({3'(c), d});
        exp_bytes.push_back(d[7:0]);
        exp_bytes.push_back({1'b1, 3'(c), 2'b00, d[9:8]});
      end
    end
  endtask

  // MCP3008 model sampled away from clk posedge
  logic       p_sck, p_ss, tail_err;
  int         r_cnt, f_cnt, hi_len, lo_len;
  logic [4:0] cmd, last_cmd;
  logic [9:0] val;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_sck = 1'b0; p_ss = 1'b1; MISO = 1'b0; r_cnt = 0; f_cnt = 0; hi_len = 100;
    end else begin
      if (p_ss && !SS1) begin
        check("ss_gap", int'(hi_len >= 2 * SCKDIV), 1);
        r_cnt = 0; f_cnt = 0; cmd = '0; lo_len = 0; MISO = 1'b0; tail_err = 1'b0;
      end
      if (!p_ss && SS1) begin
        check("sck_count", r_cnt, 17);
        check("mosi_tail", int'(tail_err), 0);
        last_cmd = cmd; hi_len = 0; MISO = 1'b0;
      end
      if (!SS1) begin
        lo_len++;
        if (!p_sck && SCK) begin
          if (r_cnt == 0) check("ss_lead", int'(lo_len - 1 >= SCKDIV), 1);
          if (r_cnt < 5) cmd = {cmd[3:0], MOSI};
          else if (MOSI !== 1'b0) tail_err = 1'b1;
          r_cnt++;
          if (r_cnt == 5) val = 10'h2A7 + 10'(cmd[2:0]);
        end
        if (p_sck && !SCK) begin
          f_cnt++;
          MISO = (f_cnt >= 7 && f_cnt <= 16) ? val[16 - f_cnt] : 1'b0;
        end
      end else begin
        hi_len++;
      end
      p_sck = SCK; p_ss = SS1;
    end
  end

  // Compare process: samples, idle lines and UART bytes against the model
  int         rx_cnt;
  bit         rx_on = 1'b0;
  bit         rx_unstable;
  logic       rx_cur;
  logic [9:0] rx_bits;
  logic [7:0] eb;
  logic [12:0] es;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_on = 1'b0;
    end else begin
      if (sample_valid) begin
        check("sample_pending", int'(exp_s.size() > 0), 1);
        if (exp_s.size() > 0) begin
          es = exp_s.pop_front();
          check("sample_ch", sample_ch, es[12:10]);
          check("sample_data", sample_data, es[9:0]);
        end
      end
      if (!busy) check("idle_lines", {SS1, SCK, MOSI, TxD}, 4'b1001);
      if (!rx_on && TxD === 1'b0) begin
        rx_on = 1'b1; rx_cnt = 0; rx_unstable = 1'b0;
      end
      if (rx_on) begin
        if (rx_cnt % BD == 0) rx_cur = TxD;
        else if (TxD !== rx_cur) rx_unstable = 1'b1;
        if (rx_cnt % BD == BD / 2) rx_bits[rx_cnt / BD] = TxD;
        if (rx_cnt == 10 * BD - 1) begin
          rx_on = 1'b0;
          check("uart_frame", {rx_bits[0], rx_bits[9], rx_unstable}, 3'b010);
          rx_log.push_back(rx_bits[8:1]);
          check("uart_pending", int'(exp_bytes.size() > 0), 1);
          if (exp_bytes.size() > 0) begin
            eb = exp_bytes.pop_front();
            check("uart_byte", rx_bits[8:1], eb);
          end
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  task automatic pulse_start(input logic [7:0] m);
    @(negedge clk);
    ch_mask = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1'b1; break; end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check(name, int'(ok), 1);
    repeat (5) @(negedge clk);
    check({name, "_drain"}, exp_bytes.size() + exp_s.size(), 0);
  endtask

  int  b;
  bit  saw_busy;

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sck", SCK, 0);
    check("rst_ss1", SS1, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_txd", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ch", sample_ch, 0);
    check("rst_data", sample_data, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // T1 single channel 1
    scan_expect(8'h02);
    b = rx_log.size();
    pulse_start(8'h02);
    wait_valid("t1_valid", 2000 + HN * 10 * BD);
    check("t1_ch", sample_ch, 1);
    check("t1_data", sample_data, 10'h2A8);
    wait_idle("t1_idle", 8000);
    check("t1_mosi_cmd", last_cmd, 5'b11001);
    check("t1_byte0", rx_log[b + HN], 8'hA8);
    check("t1_byte1", rx_log[b + HN + 1], 8'h92);

    // T2 channels 0 and 7, with start and mask churn mid-scan
    scan_expect(8'h81);
    check("t2_model0", exp_bytes[HN], 8'hA7);
    check("t2_model3", exp_bytes[HN + 3], 8'hF2);
    b = rx_log.size();
    pulse_start(8'h81);
    repeat (300) @(negedge clk);
    pulse_start(8'hFF);
    wait_idle("t2_idle", 16000);
    check("t2_count", rx_log.size() - b, 4 + HN);
    check("t2_b0", rx_log[b + HN], 8'hA7);
    check("t2_b1", rx_log[b + HN + 1], 8'h82);
    check("t2_b2", rx_log[b + HN + 2], 8'hAE);
    check("t2_b3", rx_log[b + HN + 3], 8'hF2);

    // T3 empty mask is ignored
    pulse_start(8'h00);
    saw_busy = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("t3_no_busy", int'(saw_busy), 0);

    // T4 continuous dropped during the second scan
    continuous = 1'b1;
    scan_expect(8'h01);
    scan_expect(8'h01);
    b = rx_log.size();
    pulse_start(8'h01);
    wait_valid("t4_valid1", 2000 + HN * 10 * BD);
    wait_valid("t4_valid2", 8000 + HN * 10 * BD);
    continuous = 1'b0;
    wait_idle("t4_idle", 8000);
    check("t4_count", rx_log.size() - b, 2 * (2 + HN));

    // T5 asynchronous reset during TX_LO data bit 3
    scan_expect(8'h01);
    pulse_start(8'h01);
    wait_valid("t5_valid", 2000 + HN * 10 * BD);
    repeat (4 * BD + 100) @(negedge clk);
    check("t5_pre_txd", TxD, 0);
    #5 rst_n = 1'b0;
    #1;
    check("t5_txd", TxD, 1);
    check("t5_ss1", SS1, 1);
    check("t5_sck", SCK, 0);
    check("t5_busy", busy, 0);
    exp_bytes.delete();
    exp_s.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    scan_expect(8'h02);
    b = rx_log.size();
    pulse_start(8'h02);
    wait_idle("t5_restart", 8000 + HN * 10 * BD);
    check("t5_byte0", rx_log[b + HN], 8'hA8);

`ifdef SCAN_HEADER_EN
    // T6 header framing
    scan_expect(8'h05);
    b = rx_log.size();
    pulse_start(8'h05);
    wait_idle("t6_idle", 20000);
    check("t6_h0", rx_log[b], 8'hA5);
    check("t6_h1", rx_log[b + 1], 8'h05);
    check("t6_r0", rx_log[b + 2], 8'hA7);
    check("t6_r1", rx_log[b + 3], 8'h82);
    check("t6_r2", rx_log[b + 4], 8'hA9);
    check("t6_r3", rx_log[b + 5], 8'hA2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
